rgb2hsv_seq: RTL and testbench
==============================

Name: rgb2hsv_seq

Overview:
- Sequential RGB-to-HSV converter; the stage directly upstream of the HSV-to-RGB back-converter in the colour-reduction path.
- Takes one 24-bit RGB pixel per handshake and produces packed 8-bit H/S/V in the {H,S,V} format that stage consumes.
- Uses one shared restoring divider for saturation and hue, so throughput is traded for area.
- Holds its result under downstream backpressure.

Parameters:
- SECTOR, default 43: hue units per 60 degrees; hue scale factor.
- G_BASE, default 85: hue offset when green is the maximum.
- B_BASE, default 171: hue offset when blue is the maximum.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- in_rgb  input  24  pixel as {R[23:16], G[15:8], B[7:0]}.
- in_valid  input  1  in_rgb is valid.
- in_ready  output  1  block can accept a pixel; high only in IDLE.
- out_hsv  output  24  result as {H[23:16], S[15:8], V[7:0]}.
- out_valid  output  1  out_hsv is valid.
- out_ready  input  1  downstream accepts out_hsv.

Behaviour:
- Reset: clk and reset_n per "Already decided". While reset_n is low at a clock edge:
  - state goes to IDLE; out_hsv = 0; out_valid = 0; in_ready = 0 for that cycle.
  - Reset mid-conversion aborts it; the pixel is discarded and never emitted.
- Accept: when in_valid && in_ready at an edge, latch R, G, B and go to PREP.
- PREP (1 cycle):
  - max, min, delta = max - min (8 bit), V = max.
  - Max selection priority on ties: R, then G, then B.
  - Signed numerator num: R max -> G-B; G max -> B-R; B max -> R-G. Store sign and |num|.
  - base: R max -> 0; G max -> G_BASE; B max -> B_BASE.
  - If delta == 0: H = 0, S = 0, go directly to DONE.
  - Otherwise go to DIV_S.
- DIV_S (16 cycles): restoring division, one quotient bit per cycle.
  - S = floor(delta*255 / max). Dividend 16 bit, divisor 8 bit, quotient keeps the low 8 bits; it is always <= 255.
- DIV_H (16 cycles): same divider.
  - q = floor(|num|*SECTOR / delta); q <= 43.
  - H = (base + q) mod 256 if num >= 0, else (base - q) mod 256. 8-bit wrap-around is intended.
- DONE: out_hsv = {H,S,V}, out_valid = 1.
  - Outputs stay stable until out_ready is high at an edge; then out_valid drops and state returns to IDLE.
  - in_ready rises in the following cycle. No new pixel is accepted in the same cycle the result is consumed.
- Latency, with accept edge = cycle 0:
  - Chromatic pixel: out_valid is high from cycle 34.
  - delta == 0: out_valid is high from cycle 2.
- All arithmetic truncates; no rounding.
- in_rgb is ignored outside the accept edge.
- out_ready is ignored unless out_valid = 1.

Test Plan:
- Reset, then hold reset_n low mid-DIV_S with in_valid=1 -> out_valid stays 0 and out_hsv = 0; after release, in_ready = 1 within 1 cycle.
- Primaries: in_rgb = FF0000 / 00FF00 / 0000FF -> out_hsv = 00FFFF / 55FFFF / ABFFFF; out_valid exactly 34 cycles after accept.
- Gray and black: 808080 -> 000080 at cycle 2; 000000 -> 000000 at cycle 2.
- Fractional and wrap: C86432 (200,100,50) -> H=0E, S=BF, V=C8; FF00FF (R/B tie, R wins, negative num) -> D5FFFF; FF8000 -> 15FFFF.
- Backpressure: out_ready low for 10 cycles after out_valid -> out_hsv stable, in_ready = 0 throughout; raise out_ready -> out_valid falls next edge, in_ready rises the cycle after.
- Back-to-back: keep in_valid high with out_ready = 1 for 4 random pixels -> every result matches a floating-point model truncated as specified; no pixel dropped or duplicated.

Source files
------------

// File: rtl/rgb2hsv_seq.sv
// Sequential RGB-to-HSV converter with one shared restoring divider.
// Saturation and hue are divided in turn, 16 cycles each.
module rgb2hsv_seq #(
    parameter int unsigned SECTOR = 43,
    parameter int unsigned G_BASE = 85,
    parameter int unsigned B_BASE = 171
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [23:0] in_rgb,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [23:0] out_hsv,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam logic [15:0] SEC = 16'(SECTOR);
    localparam logic [7:0]  GB  = 8'(G_BASE);
    localparam logic [7:0]  BB  = 8'(B_BASE);

    typedef enum logic [2:0] {IDLE, PREP, DIV_S, DIV_H, DONE} state_t;

    state_t      state_q, state_d;
    logic [23:0] rgb_q, rgb_d;
    logic [7:0]  v_q, v_d;
    logic [7:0]  delta_q, delta_d;
    logic [7:0]  abs_q, abs_d;
    logic        neg_q, neg_d;
    logic [7:0]  base_q, base_d;
    logic [7:0]  div_q, div_d;
    logic [7:0]  rem_q, rem_d;
    logic [15:0] quo_q, quo_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  s_q, s_d;
    logic [23:0] hsv_q, hsv_d;

    logic [7:0]  r, g, b, mx, mn, dl, an, bs;
    logic        r_max, g_max;
    logic [8:0]  nm;
    logic [8:0]  trial;
    logic        ge;
    logic [7:0]  rem_nx;
    logic [15:0] quo_nx;
    logic [15:0] s_dvd, h_dvd;
    logic [7:0]  h;

    assign in_ready  = reset_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_hsv   = hsv_q;

    always_comb begin
        r = rgb_q[23:16];
        g = rgb_q[15:8];
        b = rgb_q[7:0];
        // Ties resolve to R first, then G, then B
        r_max = (r >= g) && (r >= b);
        g_max = !r_max && (g >= b);
        mx = r_max ? r : (g_max ? g : b);
        mn = (r <= g) ? ((r <= b) ? r : b) : ((g <= b) ? g : b);
        dl = mx - mn;
        if (r_max) begin
            nm = {1'b0, g} - {1'b0, b};
            bs = 8'd0;
        end else if (g_max) begin
            nm = {1'b0, b} - {1'b0, r};
            bs = GB;
        end else begin
            nm = {1'b0, r} - {1'b0, g};
            bs = BB;
        end
        an = nm[8] ? 8'(-nm) : nm[7:0];

        trial  = {rem_q, quo_q[15]};
        ge     = trial >= {1'b0, div_q};
        rem_nx = ge ? 8'(trial - {1'b0, div_q}) : trial[7:0];
        quo_nx = {quo_q[14:0], ge};

        s_dvd = {8'd0, dl} * 16'd255;
        h_dvd = {8'd0, abs_q} * SEC;
        // Hue wraps modulo 256 on purpose
        h = neg_q ? (base_q - quo_nx[7:0]) : (base_q + quo_nx[7:0]);
    end

    always_comb begin
        state_d = state_q;
        rgb_d   = rgb_q;
        v_d     = v_q;
        delta_d = delta_q;
        abs_d   = abs_q;
        neg_d   = neg_q;
        base_d  = base_q;
        div_d   = div_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        hsv_d   = hsv_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rgb_d   = in_rgb;
                    state_d = PREP;
                end
            end
            PREP: begin
                v_d     = mx;
                delta_d = dl;
                abs_d   = an;
                neg_d   = nm[8];
                base_d  = bs;
                if (dl == 8'd0) begin
                    hsv_d   = {16'd0, mx};
                    state_d = DONE;
                end else begin
                    div_d   = mx;
                    rem_d   = 8'd0;
                    quo_d   = s_dvd;
                    cnt_d   = 4'd0;
                    state_d = DIV_S;
                end
            end
            DIV_S: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    s_d     = quo_nx[7:0];
                    div_d   = delta_q;
                    rem_d   = 8'd0;
                    quo_d   = h_dvd;
                    state_d = DIV_H;
                end
            end
            DIV_H: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    hsv_d   = {h, s_q, v_q};
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rgb_q   <= '0;
            v_q     <= '0;
            delta_q <= '0;
            abs_q   <= '0;
            neg_q   <= 1'b0;
            base_q  <= '0;
            div_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            s_q     <= '0;
            hsv_q   <= '0;
        end else begin
            state_q <= state_d;
            rgb_q   <= rgb_d;
            v_q     <= v_d;
            delta_q <= delta_d;
            abs_q   <= abs_d;
            neg_q   <= neg_d;
            base_q  <= base_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            hsv_q   <= hsv_d;
        end
    end

endmodule

// File: tb/tb_rgb2hsv_seq.sv
// Bench for rgb2hsv_seq: vector table, backpressure, reset abort and
// back-to-back pixels checked through an expected-result queue.
module tb_rgb2hsv_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [23:0] in_rgb;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] out_hsv;
    logic        out_valid;
    logic        out_ready;

    always #5 clk = ~clk;

    rgb2hsv_seq dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_rgb    (in_rgb),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_hsv   (out_hsv),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        logic [23:0] rgb;
        logic [23:0] hsv;
        int          lat;
    } vec_t;

    vec_t        tbl[10];
    logic [23:0] sb[$];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", nm, got, exp);
        end
    endtask

    function automatic logic [23:0] model(input logic [23:0] p);
        int r, g, b, mx, mn, d, num, base, q, s, h;
        r = int'(p[23:16]);
        g = int'(p[15:8]);
        b = int'(p[7:0]);
        if (r >= g && r >= b) begin
            mx = r; num = g - b; base = 0;
        end else if (g >= b) begin
            mx = g; num = b - r; base = 85;
        end else begin
            mx = b; num = r - g; base = 171;
        end
        mn = (r < g) ? r : g;
        mn = (b < mn) ? b : mn;
        d = mx - mn;
        if (d == 0) return {16'h0000, 8'(mx)};
        s = int'($floor(real'(d) * 255.0 / real'(mx)));
        q = int'($floor(real'((num < 0) ? -num : num) * 43.0 / real'(d)));
        h = (num >= 0) ? base + q : base - q;
        h = ((h % 256) + 256) % 256;
        return {8'(h), 8'(s), 8'(mx)};
    endfunction

    task automatic send_one(input logic [23:0] pix, input logic [23:0] exp_hsv,
                            input int exp_lat, input int hold);
        int k;
        logic [23:0] exp;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("in_ready_wait", int'(in_ready), 1);
        in_rgb   = pix;
        in_valid = 1'b1;
        sb.push_back(exp_hsv);
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                in_valid = 1'b0;
                in_rgb   = 24'($urandom);
            end
        end while (!out_valid && k < 100);
        chk("latency", k, exp_lat);
        exp = 24'h0;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty got none exp entry");
        end else begin
            exp = sb.pop_front();
            chk("hsv", int'(out_hsv), int'(exp));
        end
        repeat (hold) begin
            @(negedge clk);
            chk("hold_hsv", int'(out_hsv), int'(exp));
            chk("hold_vr", int'({out_valid, in_ready}), 2);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("consume_vr", int'({out_valid, in_ready}), 1);
    endtask

    initial begin
        int k, got;
        logic seen;
        tbl[0] = '{24'hFF0000, 24'h00FFFF, 34};
        tbl[1] = '{24'h00FF00, 24'h55FFFF, 34};
        tbl[2] = '{24'h0000FF, 24'hABFFFF, 34};
        tbl[3] = '{24'h808080, 24'h000080, 2};
        tbl[4] = '{24'h000000, 24'h000000, 2};
        tbl[5] = '{24'hC86432, 24'h0EBFC8, 34};
        tbl[6] = '{24'hFF00FF, 24'hD5FFFF, 34};
        tbl[7] = '{24'hFF8000, 24'h15FFFF, 34};
        tbl[8] = '{24'hFFFFFF, 24'h0000FF, 2};
        tbl[9] = '{24'h3040FF, 24'hA8CFFF, 34};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_rgb    = 24'h0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_hsv", int'(out_hsv), 0);
        chk("rst_ready", int'(in_ready), 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", int'(in_ready), 1);

        for (int i = 0; i < 10; i++)
            send_one(tbl[i].rgb, tbl[i].hsv, tbl[i].lat, 0);

        // Backpressure on a fractional pixel
        send_one(24'hC86432, 24'h0EBFC8, 34, 10);

        // Reset while dividing: pixel must vanish
        @(negedge clk);
        in_rgb   = 24'hC86432;
        in_valid = 1'b1;
        repeat (6) @(negedge clk);
        reset_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_valid", int'(out_valid), 0);
            chk("midrst_hsv", int'(out_hsv), 0);
            chk("midrst_ready", int'(in_ready), 0);
        end
        reset_n  = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_release_ready", int'(in_ready), 1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= out_valid;
        end
        chk("midrst_no_output", int'(seen), 0);

        // Back-to-back with downstream always ready
        out_ready = 1'b1;
        fork
            begin
                logic [23:0] pix;
                for (int i = 0; i < 4; i++) begin
                    pix = 24'($urandom);
                    if (i == 2) pix = {pix[7:0], pix[7:0], pix[7:0]};
                    in_rgb   = pix;
                    in_valid = 1'b1;
                    k = 0;
                    while (!in_ready && k < 200) begin
                        @(negedge clk);
                        k++;
                    end
                    sb.push_back(model(pix));
                    @(negedge clk);
                end
                in_valid = 1'b0;
            end
            begin
                logic [23:0] exp;
                int t;
                got = 0;
                t = 0;
                while (got < 4 && t < 400) begin
                    @(negedge clk);
                    t++;
                    if (out_valid && out_ready) begin
                        got++;
                        if (sb.size() == 0) begin
                            errors++;
                            $display("FAIL b2b_extra got output exp none");
                        end else begin
                            exp = sb.pop_front();
                            chk("b2b_hsv", int'(out_hsv), int'(exp));
                        end
                    end
                end
                chk("b2b_count", got, 4);
            end
        join
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= out_valid;
        end
        chk("b2b_no_dup", int'(seen), 0);
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
